// File: rtl/dmem_if.sv
// Memory-stage data request/response bundle between the pipeline and the data-memory responder.
interface dmem_if;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] AddrM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        Ready;
  logic        MisalignM;

  modport master (
    output MemReadM, MemWriteM, funct3M, AddrM, WriteDataM,
    input  ReadDataM, Ready, MisalignM
  );

  modport slave (
    input  MemReadM, MemWriteM, funct3M, AddrM, WriteDataM,
    output ReadDataM, Ready, MisalignM
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: latches one load/store, pulses Ready LATENCY cycles later.
// Define DMEM_MISALIGN_CHECK_EN to flag and suppress misaligned halfword/word accesses.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned BW = AW + 2;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          w_accept;

  logic [2:0]    r_f3;
  logic [BW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_is_write;

  logic          r_ready;
  logic [31:0]   r_rdata;
  logic          r_misalign;

  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [2:0]    w_f3;
  logic [BW-1:0] w_addr;
  logic          w_is_write;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic          w_valid;
  logic          w_misalign;
  logic [31:0]   w_rdata_next;
  logic          w_unused_addr;

  assign w_unused_addr = ^bus.AddrM[31:BW];

  // State and countdown register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.MemReadM || bus.MemWriteM) begin
          w_accept     = 1'b1;
          w_cnt_next   = CW'(LATENCY - 1);
          w_state_next = (LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Request capture; later requests are ignored until DONE has passed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f3       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
    end else if (w_accept) begin
      r_f3       <= bus.funct3M;
      r_addr     <= bus.AddrM[BW-1:0];
      r_wdata    <= bus.WriteDataM;
      r_is_write <= bus.MemWriteM;
    end
  end

  // Live inputs only matter when a one-cycle access goes straight from IDLE to DONE
  always_comb begin
    if (r_state == IDLE) begin
      w_f3       = bus.funct3M;
      w_addr     = bus.AddrM[BW-1:0];
      w_is_write = bus.MemWriteM;
    end else begin
      w_f3       = r_f3;
      w_addr     = r_addr;
      w_is_write = r_is_write;
    end
  end

  assign w_word = r_mem[w_addr[BW-1:2]];
  assign w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    case (w_addr[1:0])
      2'b00:   w_byte = w_word[7:0];
      2'b01:   w_byte = w_word[15:8];
      2'b10:   w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
  end

  // Size/sign decode; LBU/LHU encodings are not valid for stores
  always_comb begin
    w_valid = 1'b0;
    w_load  = '0;
    case (w_f3)
      3'b000: begin w_valid = 1'b1;        w_load = {{24{w_byte[7]}}, w_byte}; end
      3'b001: begin w_valid = 1'b1;        w_load = {{16{w_half[15]}}, w_half}; end
      3'b010: begin w_valid = 1'b1;        w_load = w_word; end
      3'b100: begin w_valid = !w_is_write; w_load = {24'd0, w_byte}; end
      3'b101: begin w_valid = !w_is_write; w_load = {16'd0, w_half}; end
      default: begin w_valid = 1'b0;       w_load = '0; end
    endcase
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_misalign = w_valid &&
                      (((w_f3[1:0] == 2'b01) && w_addr[0]) ||
                       ((w_f3 == 3'b010) && (w_addr[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_rdata_next = ((w_state_next == DONE) && !w_is_write && w_valid && !w_misalign)
                        ? w_load : '0;

  // Response registers: valid for exactly the DONE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready    <= 1'b0;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_ready    <= (w_state_next == DONE);
      r_rdata    <= w_rdata_next;
      r_misalign <= (w_state_next == DONE) && w_misalign;
    end
  end

  // Store commit at the end of DONE; reset in the same cycle aborts it
  always_ff @(posedge clk) begin
    if (!rst && (r_state == DONE) && r_is_write && w_valid && !w_misalign) begin
      case (r_f3)
        3'b000: begin
          case (r_addr[1:0])
            2'b00:   r_mem[r_addr[BW-1:2]][7:0]   <= r_wdata[7:0];
            2'b01:   r_mem[r_addr[BW-1:2]][15:8]  <= r_wdata[7:0];
            2'b10:   r_mem[r_addr[BW-1:2]][23:16] <= r_wdata[7:0];
            default: r_mem[r_addr[BW-1:2]][31:24] <= r_wdata[7:0];
          endcase
        end
        3'b001: begin
          if (r_addr[1]) r_mem[r_addr[BW-1:2]][31:16] <= r_wdata[15:0];
          else           r_mem[r_addr[BW-1:2]][15:0]  <= r_wdata[15:0];
        end
        default: r_mem[r_addr[BW-1:2]] <= r_wdata;
      endcase
    end
  end

  assign bus.Ready     = r_ready;
  assign bus.ReadDataM = r_rdata;
  assign bus.MisalignM = r_misalign;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table of single accesses plus hand-written
// back-to-back and reset-abort sequences.
module tb_dmem_responder;
  localparam int unsigned LAT = 2;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_if bus();

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    end
  endtask

  // One access: drive for the accept cycle, scramble inputs afterwards, wait for Ready
  task automatic access(input vec_t v);
    int k;
    @(negedge clk);
    bus.MemReadM   = v.rd;
    bus.MemWriteM  = v.wr;
    bus.funct3M    = v.f3;
    bus.AddrM      = v.addr;
    bus.WriteDataM = v.wdata;
    @(negedge clk);
    bus.MemReadM   = 1'b0;
    bus.MemWriteM  = 1'b0;
    bus.funct3M    = 3'($urandom);
    bus.AddrM      = $urandom;
    bus.WriteDataM = $urandom;
    k = 1;
    while (!bus.Ready && k < 16) begin
      @(negedge clk);
      k++;
    end
    check({v.name, " latency"}, 32'(k), 32'(LAT));
    check({v.name, " rdata"}, bus.ReadDataM, v.exp_rd);
    check({v.name, " misalign"}, {31'd0, bus.MisalignM}, {31'd0, v.exp_mis});
  endtask

  logic [31:0] held_addr [3];
  logic [31:0] held_exp  [3];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    vt.push_back('{"sw 0x10",     1'b0, 1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0, 1'b0});
    vt.push_back('{"lw 0x10",     1'b1, 1'b0, 3'b010, 32'h10,   32'h0, 32'hDEADBEEF, 1'b0});
    vt.push_back('{"sb 0x13",     1'b0, 1'b1, 3'b000, 32'h13,   32'h80, 32'h0, 1'b0});
    vt.push_back('{"lb 0x13",     1'b1, 1'b0, 3'b000, 32'h13,   32'h0, 32'hFFFFFF80, 1'b0});
    vt.push_back('{"lbu 0x13",    1'b1, 1'b0, 3'b100, 32'h13,   32'h0, 32'h00000080, 1'b0});
    vt.push_back('{"lw after sb", 1'b1, 1'b0, 3'b010, 32'h10,   32'h0, 32'h80ADBEEF, 1'b0});
    vt.push_back('{"lh 0x10",     1'b1, 1'b0, 3'b001, 32'h10,   32'h0, 32'hFFFFBEEF, 1'b0});
    vt.push_back('{"lhu 0x12",    1'b1, 1'b0, 3'b101, 32'h12,   32'h0, 32'h000080AD, 1'b0});
    vt.push_back('{"sh 0x12",     1'b0, 1'b1, 3'b001, 32'h12,   32'hAAAA7FFF, 32'h0, 1'b0});
    vt.push_back('{"lw after sh", 1'b1, 1'b0, 3'b010, 32'h10,   32'h0, 32'h7FFFBEEF, 1'b0});
    vt.push_back('{"lb 0x11",     1'b1, 1'b0, 3'b000, 32'h11,   32'h0, 32'hFFFFFFBE, 1'b0});
    vt.push_back('{"sw 0x20",     1'b0, 1'b1, 3'b010, 32'h20,   32'h11223344, 32'h0, 1'b0});
    vt.push_back('{"lw 0x22",     1'b1, 1'b0, 3'b010, 32'h22,   32'h0, MIS ? 32'h0 : 32'h11223344, MIS});
    vt.push_back('{"lh 0x21",     1'b1, 1'b0, 3'b001, 32'h21,   32'h0, MIS ? 32'h0 : 32'h00003344, MIS});
    vt.push_back('{"sw 0x1000",   1'b0, 1'b1, 3'b010, 32'h1000, 32'hCAFEF00D, 32'h0, 1'b0});
    vt.push_back('{"lw wrap 0x0", 1'b1, 1'b0, 3'b010, 32'h0,    32'h0, 32'hCAFEF00D, 1'b0});
    vt.push_back('{"ld f3=011",   1'b1, 1'b0, 3'b011, 32'h10,   32'h0, 32'h0, 1'b0});
    vt.push_back('{"st f3=011",   1'b0, 1'b1, 3'b011, 32'h10,   32'hFFFFFFFF, 32'h0, 1'b0});
    vt.push_back('{"lw no write", 1'b1, 1'b0, 3'b010, 32'h10,   32'h0, 32'h7FFFBEEF, 1'b0});
    vt.push_back('{"rd+wr store", 1'b1, 1'b1, 3'b010, 32'h30,   32'h00000055, 32'h0, 1'b0});
    vt.push_back('{"lw 0x30",     1'b1, 1'b0, 3'b010, 32'h30,   32'h0, 32'h00000055, 1'b0});
    vt.push_back('{"sw 0x21",     1'b0, 1'b1, 3'b010, 32'h21,   32'hAAAAAAAA, 32'h0, MIS});
    vt.push_back('{"lw 0x20",     1'b1, 1'b0, 3'b010, 32'h20,   32'h0, MIS ? 32'h11223344 : 32'hAAAAAAAA, 1'b0});

    held_addr[0] = 32'h10; held_exp[0] = 32'h7FFFBEEF;
    held_addr[1] = 32'h30; held_exp[1] = 32'h00000055;
    held_addr[2] = 32'h0;  held_exp[2] = 32'hCAFEF00D;

    rst            = 1'b1;
    bus.MemReadM   = 1'b1;
    bus.MemWriteM  = 1'b1;
    bus.funct3M    = 3'b010;
    bus.AddrM      = 32'h0;
    bus.WriteDataM = 32'h0;
    repeat (3) @(negedge clk);
    check("reset ready", {31'd0, bus.Ready}, 32'd0);
    check("reset rdata", bus.ReadDataM, 32'd0);
    check("reset misalign", {31'd0, bus.MisalignM}, 32'd0);
    bus.MemReadM  = 1'b0;
    bus.MemWriteM = 1'b0;
    rst           = 1'b0;

    foreach (vt[i]) access(vt[i]);

    // Load held high across three accesses; inputs scrambled outside accept cycles
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("held ready c%0d", k), {31'd0, bus.Ready},
            {31'd0, (k % 3 == 2) && (k < 9)});
      check($sformatf("held rdata c%0d", k), bus.ReadDataM,
            ((k % 3 == 2) && (k < 9)) ? held_exp[k / 3] : 32'h0);
      if (k < 9) begin
        bus.MemReadM = 1'b1;
        if (k % 3 == 0) begin
          bus.AddrM   = held_addr[k / 3];
          bus.funct3M = 3'b010;
        end else begin
          bus.AddrM   = 32'h13;
          bus.funct3M = 3'b000;
        end
      end else begin
        bus.MemReadM = 1'b0;
      end
      @(negedge clk);
    end

    // Reset during WAIT aborts the store and suppresses Ready
    bus.MemWriteM  = 1'b1;
    bus.funct3M    = 3'b010;
    bus.AddrM      = 32'h20;
    bus.WriteDataM = 32'h00001234;
    @(negedge clk);
    bus.MemWriteM = 1'b0;
    rst           = 1'b1;
    for (int k = 2; k < 6; k++) begin
      @(negedge clk);
      rst = 1'b0;
      check($sformatf("rst-wait ready c%0d", k), {31'd0, bus.Ready}, 32'd0);
    end
    access('{"lw 0x20 post-rst", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0,
             MIS ? 32'h11223344 : 32'hAAAAAAAA, 1'b0});

    // Reset during DONE still blocks the store commit
    @(negedge clk);
    bus.MemWriteM  = 1'b1;
    bus.funct3M    = 3'b010;
    bus.AddrM      = 32'h30;
    bus.WriteDataM = 32'h00000099;
    @(negedge clk);
    bus.MemWriteM = 1'b0;
    @(negedge clk);
    check("rst-done ready before rst", {31'd0, bus.Ready}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst-done ready after rst", {31'd0, bus.Ready}, 32'd0);
    access('{"lw 0x30 post-rst", 1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 32'h00000055, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
